// File: rtl/udp_pattern_tx.sv
// rtl/udp_pattern_tx.sv - UDP datagram pattern generator feeding a UDP/IP stack
//
// Purpose:
//   Emits a continuous stream of UDP datagrams while enabled. Each payload
//   starts with a 32-bit big-endian sequence number. The remaining bytes carry
//   the low byte of their own index, so the receiver can detect loss and
//   reordering. Idle cycles between datagrams are set by cfg_gap.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   enable                        level; keep generating datagrams while high
//   cfg_payload_len/gap/src/dst   configuration, sampled only when a header is launched
//   m_udp_hdr_*                   header valid/ready handshake and header fields
//   m_udp_payload_axis_*          byte stream (tdata/tvalid/tready/tlast/tuser)
//   busy                          high whenever the generator is not idle
//   sent_count                    datagrams whose last byte has been accepted
module udp_pattern_tx #(
  parameter int MAX_PAYLOAD = 1472,
  parameter int GAP_WIDTH   = 32,
  parameter int TTL         = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [15:0]          cfg_payload_len,
  input  logic [GAP_WIDTH-1:0] cfg_gap,
  input  logic [31:0]          cfg_src_ip,
  input  logic [31:0]          cfg_dst_ip,
  input  logic [15:0]          cfg_src_port,
  input  logic [15:0]          cfg_dst_port,
  output logic                 m_udp_hdr_valid,
  input  logic                 m_udp_hdr_ready,
  output logic [5:0]           m_udp_ip_dscp,
  output logic [1:0]           m_udp_ip_ecn,
  output logic [7:0]           m_udp_ip_ttl,
  output logic [31:0]          m_udp_ip_source_ip,
  output logic [31:0]          m_udp_ip_dest_ip,
  output logic [15:0]          m_udp_source_port,
  output logic [15:0]          m_udp_dest_port,
  output logic [15:0]          m_udp_length,
  output logic [15:0]          m_udp_checksum,
  output logic [7:0]           m_udp_payload_axis_tdata,
  output logic                 m_udp_payload_axis_tvalid,
  input  logic                 m_udp_payload_axis_tready,
  output logic                 m_udp_payload_axis_tlast,
  output logic                 m_udp_payload_axis_tuser,
  output logic                 busy,
  output logic [31:0]          sent_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          len_q;
  logic [31:0]          src_ip_q, dst_ip_q;
  logic [15:0]          src_port_q, dst_port_q;
  logic [GAP_WIDTH-1:0] gap_cfg_q;
  logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0]          idx_q, idx_d;
  logic [31:0]          seq_q;
  logic [31:0]          sent_q;

  logic                 latch_cfg;
  logic                 dgram_done;
  logic [15:0]          eff_len;
  logic                 last_byte;
  logic [7:0]           pattern_byte;

  // Zero-length datagrams are promoted to one byte so every datagram carries a tlast.
  always_comb begin
    eff_len = cfg_payload_len;
    if (cfg_payload_len == 16'd0) begin
      eff_len = 16'd1;
    end else if (cfg_payload_len > 16'(MAX_PAYLOAD)) begin
      eff_len = 16'(MAX_PAYLOAD);
    end
  end

  assign last_byte = (idx_q == len_q - 16'd1);

  // First four bytes carry the sequence number MSB first; later bytes echo their index.
  always_comb begin
    pattern_byte = idx_q[7:0];
    if (idx_q < 16'd4) begin
      case (idx_q[1:0])
        2'd0:    pattern_byte = seq_q[31:24];
        2'd1:    pattern_byte = seq_q[23:16];
        2'd2:    pattern_byte = seq_q[15:8];
        default: pattern_byte = seq_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d                   = state_q;
    idx_d                     = idx_q;
    gap_cnt_d                 = gap_cnt_q;
    latch_cfg                 = 1'b0;
    dgram_done                = 1'b0;
    busy                      = 1'b1;
    m_udp_hdr_valid           = 1'b0;
    m_udp_payload_axis_tvalid = 1'b0;
    m_udp_payload_axis_tlast  = 1'b0;
    m_udp_payload_axis_tdata  = 8'd0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (enable) begin
          latch_cfg = 1'b1;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        m_udp_hdr_valid = 1'b1;
        if (m_udp_hdr_ready) begin
          idx_d   = 16'd0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        m_udp_payload_axis_tvalid = 1'b1;
        m_udp_payload_axis_tdata  = pattern_byte;
        m_udp_payload_axis_tlast  = last_byte;
        if (m_udp_payload_axis_tready) begin
          if (last_byte) begin
            dgram_done = 1'b1;
            gap_cnt_d  = gap_cfg_q;
            state_d    = S_GAP;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
      default: begin
        // A count of 0 or 1 both leave after this cycle: 0 means "no gap" yet
        // still spends the one cycle in GAP, 1 reaches zero on this decrement.
        if (gap_cnt_q <= GAP_WIDTH'(1)) begin
          if (enable) begin
            latch_cfg = 1'b1;
            state_d   = S_HDR;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= 16'd0;
      src_ip_q   <= 32'd0;
      dst_ip_q   <= 32'd0;
      src_port_q <= 16'd0;
      dst_port_q <= 16'd0;
      gap_cfg_q  <= '0;
      gap_cnt_q  <= '0;
      idx_q      <= 16'd0;
      seq_q      <= 32'd0;
      sent_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_cnt_q <= gap_cnt_d;
      if (latch_cfg) begin
        len_q      <= eff_len;
        src_ip_q   <= cfg_src_ip;
        dst_ip_q   <= cfg_dst_ip;
        src_port_q <= cfg_src_port;
        dst_port_q <= cfg_dst_port;
        gap_cfg_q  <= cfg_gap;
      end
      if (dgram_done) begin
        seq_q  <= seq_q + 32'd1;
        sent_q <= sent_q + 32'd1;
      end
    end
  end

  assign m_udp_ip_dscp            = 6'd0;
  assign m_udp_ip_ecn             = 2'd0;
  assign m_udp_ip_ttl             = 8'(TTL);
  assign m_udp_ip_source_ip       = src_ip_q;
  assign m_udp_ip_dest_ip         = dst_ip_q;
  assign m_udp_source_port        = src_port_q;
  assign m_udp_dest_port          = dst_port_q;
  assign m_udp_length             = len_q + 16'd8;
  assign m_udp_checksum           = 16'd0;
  assign m_udp_payload_axis_tuser = 1'b0;
  assign sent_count               = sent_q;

endmodule

// File: tb/tb_udp_pattern_tx.sv
// tb/tb_udp_pattern_tx.sv - directed self-checking bench for udp_pattern_tx
module tb_udp_pattern_tx;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] cfg_payload_len;
  logic [31:0] cfg_gap;
  logic [31:0] cfg_src_ip;
  logic [31:0] cfg_dst_ip;
  logic [15:0] cfg_src_port;
  logic [15:0] cfg_dst_port;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [5:0]  ip_dscp;
  logic [1:0]  ip_ecn;
  logic [7:0]  ip_ttl;
  logic [31:0] ip_source_ip;
  logic [31:0] ip_dest_ip;
  logic [15:0] source_port;
  logic [15:0] dest_port;
  logic [15:0] udp_length;
  logic [15:0] udp_checksum;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;
  logic        busy;
  logic [31:0] sent_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rx_data [0:2047];
  logic       rx_last [0:2047];
  int         rx_n;
  int         cyc;

  udp_pattern_tx #(
    .MAX_PAYLOAD(1472),
    .GAP_WIDTH  (32),
    .TTL        (64)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .enable                    (enable),
    .cfg_payload_len           (cfg_payload_len),
    .cfg_gap                   (cfg_gap),
    .cfg_src_ip                (cfg_src_ip),
    .cfg_dst_ip                (cfg_dst_ip),
    .cfg_src_port              (cfg_src_port),
    .cfg_dst_port              (cfg_dst_port),
    .m_udp_hdr_valid           (hdr_valid),
    .m_udp_hdr_ready           (hdr_ready),
    .m_udp_ip_dscp             (ip_dscp),
    .m_udp_ip_ecn              (ip_ecn),
    .m_udp_ip_ttl              (ip_ttl),
    .m_udp_ip_source_ip        (ip_source_ip),
    .m_udp_ip_dest_ip          (ip_dest_ip),
    .m_udp_source_port         (source_port),
    .m_udp_dest_port           (dest_port),
    .m_udp_length              (udp_length),
    .m_udp_checksum            (udp_checksum),
    .m_udp_payload_axis_tdata  (tdata),
    .m_udp_payload_axis_tvalid (tvalid),
    .m_udp_payload_axis_tready (tready),
    .m_udp_payload_axis_tlast  (tlast),
    .m_udp_payload_axis_tuser  (tuser),
    .busy                      (busy),
    .sent_count                (sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] s, input int i);
    if (i < 4) return 8'(s >> (8 * (3 - i)));
    return 8'(i);
  endfunction

  // Ticks until hdr_valid is seen; cyc returns the number of edges waited.
  task automatic wait_hdr();
    cyc = 0;
    while (hdr_valid !== 1'b1 && cyc < 5000) begin
      tick();
      cyc++;
    end
    if (hdr_valid !== 1'b1) check("hdr_timeout", 32'(hdr_valid), 32'd1);
  endtask

  // Accepts n payload bytes. With toggle set, tready alternates and any byte
  // offered while not ready must reappear unchanged on the following cycle.
  task automatic collect(input int n, input bit toggle);
    int         guard;
    int         bubbles;
    bit         have_hold;
    logic [7:0] hold_d;
    logic       hold_l;
    guard = 0; bubbles = 0; have_hold = 0; rx_n = 0;
    hold_d = 8'd0; hold_l = 1'b0;
    while (rx_n < n && guard < 5000) begin
      tready = toggle ? guard[0] : 1'b1;
      if (have_hold) begin
        check("hold_tvalid", 32'(tvalid), 32'd1);
        check("hold_tdata", 32'(tdata), 32'(hold_d));
        check("hold_tlast", 32'(tlast), 32'(hold_l));
        have_hold = 0;
      end
      if (tvalid !== 1'b1) bubbles++;
      if (tvalid === 1'b1 && tready === 1'b1) begin
        rx_data[rx_n] = tdata;
        rx_last[rx_n] = tlast;
        rx_n++;
      end else if (tvalid === 1'b1) begin
        hold_d = tdata;
        hold_l = tlast;
        have_hold = 1;
      end
      tick();
      guard++;
    end
    tready = 1'b1;
    if (rx_n < n) check("payload_timeout", 32'(rx_n), 32'(n));
    if (!toggle) check("bubbles", 32'(bubbles), 32'd0);
  endtask

  task automatic check_dgram(input string tag, input logic [31:0] s, input int len);
    check({tag, "_count"}, 32'(rx_n), 32'(len));
    for (int i = 0; i < rx_n; i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(rx_data[i]), 32'(exp_byte(s, i)));
      check($sformatf("%s_last%0d", tag, i), 32'(rx_last[i]), 32'(i == len - 1));
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; hdr_ready = 1'b1; tready = 1'b1;
    cfg_payload_len = 16'd8; cfg_gap = 32'd0;
    cfg_src_ip = 32'h0A00_0001; cfg_dst_ip = 32'hC0A8_0201;
    cfg_src_port = 16'd5000; cfg_dst_port = 16'd1234;
    tick(); tick(); tick();

    // Reset state
    check("rst_hdr_valid", 32'(hdr_valid), 32'd0);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sent", sent_count, 32'd0);
    check("rst_dest_ip", ip_dest_ip, 32'd0);

    // Basic datagram, L=8, gap=0
    rst = 1'b0; enable = 1'b1;
    wait_hdr();
    check("hdr_latency", 32'(cyc), 32'd1);
    check("hdr_length", 32'(udp_length), 32'd16);
    check("hdr_ttl", 32'(ip_ttl), 32'd64);
    check("hdr_dest_ip", ip_dest_ip, 32'hC0A8_0201);
    check("hdr_dest_port", 32'(dest_port), 32'd1234);
    check("hdr_src_ip", ip_source_ip, 32'h0A00_0001);
    check("hdr_src_port", 32'(source_port), 32'd5000);
    check("hdr_const", {ip_dscp, ip_ecn, udp_checksum, 7'd0, tuser}, 32'd0);
    check("hdr_busy", 32'(busy), 32'd1);
    tick();
    check("payload_latency", 32'(tvalid), 32'd1);
    collect(8, 0);
    check_dgram("d0", 32'd0, 8);
    check("d0_sent", sent_count, 32'd1);
    check("gap_busy", 32'(busy), 32'd1);
    check("gap_hdr_low", 32'(hdr_valid), 32'd0);
    wait_hdr();
    check("gap0_latency", 32'(cyc + 1), 32'd2);
    tick();
    collect(8, 0);
    check_dgram("d1", 32'd1, 8);

    // Header stall, config change ignored mid-datagram, tready toggling
    hdr_ready = 1'b0;
    wait_hdr();
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        cfg_dst_port = 16'd4321;
        cfg_payload_len = 16'd3;
      end
      check($sformatf("stall_valid%0d", k), 32'(hdr_valid), 32'd1);
      check($sformatf("stall_port%0d", k), 32'(dest_port), 32'd1234);
      check($sformatf("stall_len%0d", k), 32'(udp_length), 32'd16);
      tick();
    end
    cfg_dst_port = 16'd1234;
    cfg_payload_len = 16'd0;
    hdr_ready = 1'b1;
    tick();
    collect(8, 1);
    check_dgram("d2", 32'd2, 8);

    // Length clamping: 0 -> 1 byte, 2000 -> 1472 bytes
    wait_hdr();
    check("len0_length", 32'(udp_length), 32'd9);
    tick();
    collect(1, 0);
    check_dgram("d3", 32'd3, 1);
    cfg_payload_len = 16'd2000;
    wait_hdr();
    check("lenmax_length", 32'(udp_length), 32'd1480);
    tick();
    collect(1472, 0);
    check_dgram("d4", 32'd4, 1472);
    check("lenmax_byte260", 32'(rx_data[260]), 32'h04);

    // Gap of 5 cycles, then enable dropped mid-payload
    cfg_payload_len = 16'd4;
    cfg_gap = 32'd5;
    wait_hdr();
    tick();
    collect(4, 0);
    check_dgram("d5", 32'd5, 4);
    check("gap5_busy", 32'(busy), 32'd1);
    wait_hdr();
    check("gap5_latency", 32'(cyc + 1), 32'd6);
    tick();
    enable = 1'b0;
    collect(4, 0);
    check_dgram("d6", 32'd6, 4);
    check("drop_sent", sent_count, 32'd7);
    for (int k = 0; k < 5; k++) tick();
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_hdr", 32'(hdr_valid), 32'd0);
    tick(); tick();
    check("drop_hdr_stays", 32'(hdr_valid), 32'd0);

    // Reset mid-payload
    cfg_payload_len = 16'd8;
    cfg_gap = 32'd0;
    enable = 1'b1;
    wait_hdr();
    tick();
    collect(3, 0);
    rst = 1'b1;
    tick();
    check("midrst_tvalid", 32'(tvalid), 32'd0);
    check("midrst_tlast", 32'(tlast), 32'd0);
    check("midrst_hdr", 32'(hdr_valid), 32'd0);
    check("midrst_sent", sent_count, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_hdr();
    check("postrst_latency", 32'(cyc), 32'd1);
    tick();
    collect(8, 0);
    check_dgram("r0", 32'd0, 8);
    check("postrst_sent", sent_count, 32'd1);

    // Sequence wrap from 0xFFFFFFFF
    enable = 1'b0;
    tick();
    check("wrap_idle", 32'(busy), 32'd0);
    force dut.seq_q = 32'hFFFF_FFFF;
    tick();
    release dut.seq_q;
    enable = 1'b1;
    wait_hdr();
    tick();
    collect(8, 0);
    check_dgram("w0", 32'hFFFF_FFFF, 8);
    wait_hdr();
    tick();
    collect(8, 0);
    check_dgram("w1", 32'd0, 8);
    enable = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/udp_pattern_tx.md
Name: udp_pattern_tx

Overview:
- Initiator-side UDP traffic source for the board-level Ethernet examples.
- Generates a stream of UDP datagrams toward a configured destination. It drives the s_udp_* input of the UDP/IP stack in place of echoed payload.
- Each datagram carries a 32-bit sequence number followed by an incrementing byte pattern, so the far end can check loss and ordering.
- Spacing between datagrams is set by a programmable gap.

Parameters:
- MAX_PAYLOAD, 1472: upper clamp on payload bytes per datagram.
- GAP_WIDTH, 32: width of the inter-packet gap counter.
- TTL, 64: IP TTL driven on every header.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; start and continue generating datagrams.
- cfg_payload_len  in  16  payload bytes per datagram.
- cfg_gap  in  GAP_WIDTH  idle cycles between a tlast handshake and the next hdr_valid.
- cfg_src_ip  in  32  source IP address.
- cfg_dst_ip  in  32  destination IP address.
- cfg_src_port  in  16  source UDP port.
- cfg_dst_port  in  16  destination UDP port.
- m_udp_hdr_valid  out  1  header valid.
- m_udp_hdr_ready  in  1  header ready.
- m_udp_ip_dscp  out  6  constant 0.
- m_udp_ip_ecn  out  2  constant 0.
- m_udp_ip_ttl  out  8  constant TTL.
- m_udp_ip_source_ip  out  32  latched cfg_src_ip.
- m_udp_ip_dest_ip  out  32  latched cfg_dst_ip.
- m_udp_source_port  out  16  latched cfg_src_port.
- m_udp_dest_port  out  16  latched cfg_dst_port.
- m_udp_length  out  16  effective payload length + 8.
- m_udp_checksum  out  16  constant 0.
- m_udp_payload_axis_tdata  out  8  payload byte.
- m_udp_payload_axis_tvalid  out  1  payload valid.
- m_udp_payload_axis_tready  in  1  payload ready.
- m_udp_payload_axis_tlast  out  1  last payload byte.
- m_udp_payload_axis_tuser  out  1  constant 0.
- busy  out  1  high in every state except IDLE.
- sent_count  out  32  number of datagrams whose tlast has been accepted.

Behaviour:
- Reset values: hdr_valid=0, tvalid=0, tlast=0, busy=0, sent_count=0, sequence=0, state=IDLE. Latched header fields are 0.
- Reset asserted mid-datagram aborts it. All valids are low on the cycle after rst is sampled high. No tlast is emitted for the aborted datagram.

State machine:
- IDLE -> HDR when enable=1.
  - On that transition, latch all cfg_* fields.
  - Effective length L = cfg_payload_len, with 0 treated as 1 and values above MAX_PAYLOAD treated as MAX_PAYLOAD.
  - m_udp_length = L+8.
- HDR: hdr_valid=1. All header outputs stay stable until hdr_valid && hdr_ready, then go to PAYLOAD with byte index i=0.
- PAYLOAD:
  - tvalid=1.
  - Bytes i=0..3 are seq[31:24], seq[23:16], seq[15:8], seq[7:0].
  - Bytes i>=4 are i[7:0] (byte 4 = 0x04, wraps at 256).
  - If L<4, the sequence bytes are truncated to the first L bytes.
  - tlast=1 exactly when i==L-1.
  - i advances only on a tvalid && tready handshake. tdata and tlast stay stable while tready=0.
  - On the tlast handshake: seq <= seq+1 (mod 2^32), sent_count <= sent_count+1 (mod 2^32), then go to GAP with gap counter = cfg_gap.
- GAP: decrement the counter once per cycle.
  - When it reaches 0, or on entry if cfg_gap=0, go to HDR if enable=1, else IDLE.
  - cfg_gap=0 therefore gives exactly one cycle in GAP.
  - cfg_* are re-latched on every GAP->HDR transition.

Enable and config rules:
- enable deasserted during HDR or PAYLOAD does not abort; the current datagram completes.
- cfg_* changes are ignored except at latch points.

Latency:
- IDLE with enable rising: hdr_valid is high on the next cycle.
- After hdr handshake: tvalid is high on the next cycle.
- With tready held high, payload runs at 1 byte per cycle.

Throughput:
- No bubbles inside a datagram.

Test Plan:
- enable=1, L=8, gap=0, all ready high, dst 192.168.2.1:1234 -> one header with length 16 and ttl 64. Payload 00 00 00 00 04 05 06 07, tlast on byte 8. Next header's payload starts 00 00 00 01.
- hdr_ready held low 10 cycles, then tready toggled every other cycle -> header fields and tdata/tlast stable while not ready. Byte sequence unchanged, no duplicates or drops.
- cfg_payload_len=0 -> length=9, single byte 0x00 with tlast. cfg_payload_len=2000 -> length=1480, 1472 bytes, byte 260 = 0x04.
- gap=5, measure from tlast handshake -> next hdr_valid rises 6 cycles later. enable dropped mid-payload -> datagram completes, then IDLE, busy=0, sent_count incremented.
- rst pulsed mid-payload -> next cycle tvalid=0 and sent_count=0. After re-enable, the sequence restarts at 0.
- Preload sequence to 0xFFFFFFFF by generating datagrams (or via force) -> seq bytes FF FF FF FF, then 00 00 00 00 on the next datagram.
